// File: rtl/cube_scan_driver.sv
// LED cube scanner: snapshots the 512-cell cube once per frame and scans layers 0..7
// through a 64-bit serial chain. Optional macro LAYER_PWM_EN adds Duty-based dimming of HOLD.
module cube_scan_driver #(
   parameter int CLK_DIV    = 2,
   parameter int LAYER_HOLD = 1000
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic [511:0] Cells,
`ifdef LAYER_PWM_EN
   input  logic [3:0]   Duty,
`endif
   output logic         Ser_data,
   output logic         Ser_clk,
   output logic         Ser_latch,
   output logic [7:0]   Layer_en,
   output logic         Frame_done,
   output logic         Busy_shift
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int HW = (LAYER_HOLD > 1) ? $clog2(LAYER_HOLD) : 1;
   localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(LAYER_HOLD - 1);
   localparam logic [HW-1:0] HOLD_PRE  = HW'(LAYER_HOLD - 2);

   typedef enum logic [2:0] {LOAD, SHIFT, BLANK, LATCH, HOLD} state_t;

   state_t         state;
   logic [511:0]   frame_buf;
   logic [2:0]     z;
   logic [5:0]     bit_cnt;
   logic [DW-1:0]  div_cnt;
   logic           phase;
   logic [HW-1:0]  hold_cnt;
   logic [7:0]     z_onehot;
   logic           lit;

   assign z_onehot = 8'd1 << z;

`ifdef LAYER_PWM_EN
   logic [3:0] pwm_cnt;
   logic [3:0] pwm_nxt;

   // Layer_en is registered, so gate with the counter value it will be shown alongside
   assign pwm_nxt = pwm_cnt + 4'd1;
   assign lit     = (pwm_nxt < Duty);

   always_ff @(posedge Clk) begin
      if (Reset) pwm_cnt <= 4'd0;
      else       pwm_cnt <= pwm_nxt;
   end
`else
   assign lit = 1'b1;
`endif

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state      <= LOAD;
         frame_buf  <= '0;
         z          <= 3'd0;
         bit_cnt    <= 6'd0;
         div_cnt    <= '0;
         phase      <= 1'b0;
         hold_cnt   <= '0;
         Ser_data   <= 1'b0;
         Ser_clk    <= 1'b0;
         Ser_latch  <= 1'b0;
         Layer_en   <= 8'd0;
         Frame_done <= 1'b0;
         Busy_shift <= 1'b0;
      end else begin
         Ser_latch  <= 1'b0;
         Frame_done <= 1'b0;
         case (state)
            LOAD: begin
               frame_buf  <= Cells;
               z          <= 3'd0;
               bit_cnt    <= 6'd0;
               div_cnt    <= '0;
               phase      <= 1'b0;
               Ser_data   <= Cells[63];
               Ser_clk    <= 1'b0;
               Busy_shift <= 1'b1;
               state      <= SHIFT;
            end
            SHIFT: begin
               if (div_cnt != DIV_LAST) begin
                  div_cnt <= div_cnt + 1'b1;
               end else begin
                  div_cnt <= '0;
                  if (!phase) begin
                     phase   <= 1'b1;
                     Ser_clk <= 1'b1;
                  end else begin
                     phase   <= 1'b0;
                     Ser_clk <= 1'b0;
                     bit_cnt <= bit_cnt + 6'd1;
                     if (bit_cnt == 6'd63) begin
                        Busy_shift <= 1'b0;
                        Layer_en   <= 8'd0;
                        state      <= BLANK;
                     end else begin
                        // MSB-first: bit b of the layer lives at index z*64 + 63 - b
                        Ser_data <= frame_buf[{z, ~(bit_cnt + 6'd1)}];
                     end
                  end
               end
            end
            BLANK: begin
               Ser_latch <= 1'b1;
               state     <= LATCH;
            end
            LATCH: begin
               hold_cnt   <= '0;
               Layer_en   <= lit ? z_onehot : 8'd0;
               Frame_done <= (z == 3'd7) && (LAYER_HOLD == 1);
               state      <= HOLD;
            end
            HOLD: begin
               if (hold_cnt == HOLD_LAST) begin
                  if (z == 3'd7) begin
                     state <= LOAD;
                  end else begin
                     z          <= z + 3'd1;
                     div_cnt    <= '0;
                     phase      <= 1'b0;
                     Ser_data   <= frame_buf[{z + 3'd1, 6'd63}];
                     Busy_shift <= 1'b1;
                     state      <= SHIFT;
                  end
               end else begin
                  hold_cnt   <= hold_cnt + 1'b1;
                  Layer_en   <= lit ? z_onehot : 8'd0;
                  Frame_done <= (z == 3'd7) && (hold_cnt == HOLD_PRE);
               end
            end
            default: state <= LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_cube_scan_driver.sv
// Scoreboard bench for cube_scan_driver: stimulus queues expected layer words, a monitor
// reassembles each latched layer from the serial chain and checks timing and invariants.
module tb_cube_scan_driver;

   localparam int CD = 3;
`ifdef LAYER_PWM_EN
   localparam int LH = 32;
`else
   localparam int LH = 4;
`endif
   localparam int LAYER_P     = 128*CD + 2 + LH;
   localparam int FRAME_P     = 8*LAYER_P + 1;
   localparam int FIRST_LATCH = 1 + 128*CD + 1;
   localparam int FIRST_DONE  = 8*LAYER_P;

   logic         Clk = 1'b0;
   logic         Reset = 1'b1;
   logic [511:0] Cells;
   logic         Ser_data, Ser_clk, Ser_latch, Frame_done, Busy_shift;
   logic [7:0]   Layer_en;
`ifdef LAYER_PWM_EN
   logic [3:0]   Duty;
`endif

   cube_scan_driver #(.CLK_DIV(CD), .LAYER_HOLD(LH)) dut (
      .Clk(Clk), .Reset(Reset), .Cells(Cells),
`ifdef LAYER_PWM_EN
      .Duty(Duty),
`endif
      .Ser_data(Ser_data), .Ser_clk(Ser_clk), .Ser_latch(Ser_latch),
      .Layer_en(Layer_en), .Frame_done(Frame_done), .Busy_shift(Busy_shift)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic [63:0] word;
      logic [2:0]  z;
      int          lit;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [63:0] w, input int zz, input int lit);
      exp_t e;
      e.word = w;
      e.z    = 3'(zz);
      e.lit  = lit;
      q.push_back(e);
   endtask

   // ---------------- monitor ----------------
   int          cyc, latches, last_done, nbits, hold_left, lit_cnt, lo, hi;
   bit          seen_done, in_hold;
   logic [63:0] sh;
   logic        prev_clk, prev_data, prev_busy;
   exp_t        cur;
   logic [12:0] ov;

   always begin
      @(posedge Clk);
      #1;
      if (Reset) begin
         ov = {Ser_data, Ser_clk, Ser_latch, Layer_en, Frame_done, Busy_shift};
         chk("reset_outputs", ov == 13'd0, 64'(ov), 64'd0);
         cyc = 0; latches = 0; seen_done = 0; nbits = 0; in_hold = 0;
         lo = 0; hi = 0; prev_clk = 0; prev_data = 0; prev_busy = 0;
      end else begin
         cyc++;
         if (in_hold) begin
            if (Layer_en != 8'd0) begin
               lit_cnt++;
               chk("hold_layer_en", Layer_en == (8'd1 << cur.z), 64'(Layer_en), 64'(8'd1 << cur.z));
            end
            hold_left--;
            if (hold_left == 0) begin
               in_hold = 0;
               chk("hold_lit_cycles", lit_cnt == cur.lit, 64'(lit_cnt), 64'(cur.lit));
            end
         end
         if (Ser_clk && !prev_clk) begin
            sh = {sh[62:0], Ser_data};
            nbits++;
         end
         if (Ser_clk != prev_clk) begin
            if (Ser_clk) begin
               chk("ser_clk_low_len", lo == CD, 64'(lo), 64'(CD));
               hi = 1;
            end else begin
               chk("ser_clk_high_len", hi == CD, 64'(hi), 64'(CD));
               lo = Busy_shift ? 1 : 0;
            end
         end else if (Ser_clk) hi++;
         else if (Busy_shift) lo++;
         else lo = 0;
         chk("ser_clk_idle", !(Ser_clk && !Busy_shift), 64'(Ser_clk), 64'd0);
         if (Ser_data !== prev_data && Busy_shift && prev_busy)
            chk("ser_data_edge", prev_clk && !Ser_clk, 64'(Ser_clk), 64'd0);
         if (Ser_latch) begin
            chk("latch_while_clk", !Ser_clk, 64'(Ser_clk), 64'd0);
            chk("latch_layer_en", Layer_en == 8'd0, 64'(Layer_en), 64'd0);
            if (latches == 0) chk("first_latch_cycle", cyc == FIRST_LATCH, 64'(cyc), 64'(FIRST_LATCH));
            latches++;
            if (q.size() == 0) begin
               chk("unexpected_latch", 1'b0, 64'(latches), 64'd0);
               cur.z = 3'd0; cur.lit = LH;
            end else begin
               cur = q.pop_front();
               chk("layer_bits", sh == cur.word, sh, cur.word);
               chk("layer_bit_count", nbits == 64, 64'(nbits), 64'd64);
            end
            nbits = 0; in_hold = 1; hold_left = LH; lit_cnt = 0;
         end
         if (Frame_done) begin
            if (!seen_done) chk("first_frame_done_cycle", cyc == FIRST_DONE, 64'(cyc), 64'(FIRST_DONE));
            else            chk("frame_period", cyc - last_done == FRAME_P, 64'(cyc - last_done), 64'(FRAME_P));
            chk("frame_done_layers", latches % 8 == 0, 64'(latches), 64'd8);
            seen_done = 1;
            last_done = cyc;
         end
         prev_clk = Ser_clk; prev_data = Ser_data; prev_busy = Busy_shift;
      end
   end

   // ---------------- stimulus ----------------
   task automatic wait_done();
      int n = 0;
      do begin @(negedge Clk); n++; end while (!Frame_done && n < FRAME_P + 200);
      if (!Frame_done) chk("timeout_frame_done", 1'b0, 64'(n), 64'(FRAME_P));
   endtask

   task automatic wait_latches(input int cnt);
      int n = 0;
      int seen = 0;
      while (seen < cnt && n < cnt*LAYER_P + 200) begin
         @(negedge Clk); n++;
         if (Ser_latch) seen++;
      end
      if (seen < cnt) chk("timeout_latch", 1'b0, 64'(seen), 64'(cnt));
   endtask

   task automatic wait_busy();
      int n = 0;
      do begin @(negedge Clk); n++; end while (!Busy_shift && n < LAYER_P + 50);
      if (!Busy_shift) chk("timeout_busy", 1'b0, 64'(n), 64'(LAYER_P));
   endtask

   int lit_on, lit_dark;

   initial begin
`ifdef LAYER_PWM_EN
      Duty     = 4'd4;
      lit_on   = 8;
      lit_dark = 0;
`else
      lit_on   = LH;
      lit_dark = LH;
`endif
      // frame 0: only cell (0,0,0) set
      Cells = 512'h1;
      push(64'h1, 0, lit_on);
      for (int z = 1; z < 8; z++) push(64'h0, z, lit_on);
      repeat (3) @(negedge Clk);
      Reset = 1'b0;
      wait_done();

      // frame 1: all ones, cleared mid-way through layer 3's shift
      Cells = '1;
      for (int z = 0; z < 8; z++) push(64'hFFFF_FFFF_FFFF_FFFF, z, lit_on);
      wait_latches(3);
      wait_busy();
      repeat (10) @(negedge Clk);
      Cells = '0;
      wait_done();

      // frame 2: all zeros, interrupted by reset during layer 5 HOLD
      for (int z = 0; z < 8; z++) push(64'h0, z, lit_on);
      wait_latches(6);
      repeat (2) @(negedge Clk);
      Reset = 1'b1;
      q.delete();
      Cells = {64'h8000_0000_0000_0000, 64'h0, 64'h0, 64'h0, 64'h0,
               64'h0123_4567_89AB_CDEF, 64'h1, 64'h0};
`ifdef LAYER_PWM_EN
      Duty = 4'd0;
`endif
      push(64'h0, 0, lit_dark);
      push(64'h1, 1, lit_dark);
      push(64'h0123_4567_89AB_CDEF, 2, lit_dark);
      for (int z = 3; z < 7; z++) push(64'h0, z, lit_dark);
      push(64'h8000_0000_0000_0000, 7, lit_dark);
      repeat (2) @(negedge Clk);
      Reset = 1'b0;
      wait_done();
      repeat (5) @(negedge Clk);
      chk("queue_drained", q.size() == 0, 64'(q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cube_scan_driver.md
Name: cube_scan_driver

Overview:
- Downstream of conway_sim; consumes its 512-bit Cells vector (8x8x8 cube) and drives the physical LED cube.
- Cube hardware: eight layer-select lines plus a 64-bit serial-in/parallel-out shift-register chain with an output latch.
- Snapshots Cells once per frame, then scans layers 0..7: shift a layer's 64 bits, blank, latch, light that layer for a hold time.

Parameters:
CLK_DIV, 2, Clk cycles per serial-clock half period (>=1)
LAYER_HOLD, 1000, Clk cycles each layer stays lit in HOLD (>=1)

Ports:
Clk  input  1  system clock
Reset  input  1  synchronous, active-high reset
Cells  input  512  cube state; bit index = z*64 + y*8 + x
Ser_data  output  1  serial data to shift chain
Ser_clk  output  1  shift clock; chain samples on rising edge
Ser_latch  output  1  one-cycle pulse transferring the chain to the LED outputs
Layer_en  output  8  one-hot layer enable, or all zero
Frame_done  output  1  one-cycle pulse at the end of layer 7 HOLD
Busy_shift  output  1  high while in SHIFT

Behaviour:
- Reset (synchronous, active-high, any state) forces: state LOAD, z=0, bit counter 0, divider 0; all outputs 0. Layer_en stays 0 until the first LATCH after reset.
- States: LOAD -> SHIFT -> BLANK -> LATCH -> HOLD -> (SHIFT if z<7, else LOAD).
- LOAD, 1 cycle:
  - frame buffer <= Cells; z <= 0.
  - This is the only point where Cells is sampled. Changes to Cells at any other time do not affect the current frame (no tearing).
- SHIFT:
  - Sends the layer z bits in index order 63 down to 0 (buffer[z*64+63] first).
  - Per bit: Ser_data is updated on the first cycle of the bit. Ser_clk is 0 for CLK_DIV cycles, then 1 for CLK_DIV cycles.
  - Total 128*CLK_DIV cycles. Ser_data is stable for the whole bit.
  - Layer_en keeps the previously latched layer lit during SHIFT (all zero on the first frame after reset).
  - Busy_shift = 1.
- BLANK, 1 cycle: Layer_en = 0, Ser_clk = 0.
- LATCH, 1 cycle: Ser_latch = 1, Layer_en = 0.
- HOLD, LAYER_HOLD cycles: Layer_en = 1 << z.
  - On the last HOLD cycle: if z==7, Frame_done = 1 and next state is LOAD; otherwise z <= z+1 and next state is SHIFT.
  - Layer_en holds its value through LOAD and the following SHIFT.
- Ser_clk is 0 outside SHIFT. Ser_latch is never asserted while Ser_clk = 1. Layer_en is never non-zero during LATCH.
- Layer period = 128*CLK_DIV + 2 + LAYER_HOLD. Frame period = 8*layer period + 1.
- Counters:
  - Bit counter is 6 bits; it wraps 63 -> 0 at the end of SHIFT.
  - Hold counter is sized for LAYER_HOLD; no overflow is allowed.
  - z is 3 bits; it is reset to 0 explicitly in LOAD, never by wrap-around.
- Cells is a synchronous input (same clock as conway_sim); no synchronizer.

Optional Feature:
- Macro: LAYER_PWM_EN.
- Defined:
  - Adds input port Duty (4 bits) and a free-running 4-bit PWM counter, cleared by Reset.
  - In HOLD, Layer_en = (1 << z) only when PWM counter < Duty, else 0.
  - Duty = 0 gives a dark cube. Duty = 15 lights 15 of 16 cycles.
  - Duty is sampled every cycle.
  - Duty affects HOLD only. The outside-HOLD Layer_en behaviour (zero in BLANK/LATCH, previous layer held in LOAD/SHIFT) and all timing are unchanged.
- Not defined: no Duty port; Layer_en is fully on for all of HOLD.

Test Plan:
1. Reset held 3 cycles, then released; Cells = 0, CLK_DIV=1, LAYER_HOLD=4 -> all outputs 0 during reset. First Ser_latch at cycle 1+128+1 = 130 after release. Layer_en = 8'h01 from cycle 131 for 4 cycles.
2. Cells = 512'h1 (only x=0,y=0,z=0) -> layer 0: Ser_data = 1 only on the 64th bit. Layers 1-7: Ser_data = 0 throughout. Frame_done after 8*134+1 = 1073 cycles.
3. Cells changed mid-frame (during layer 3 SHIFT) from all-ones to all-zeros -> layers 3-7 still shift all ones. Next frame shifts all zeros.
4. Reset asserted during HOLD of layer 5 -> next cycle: Layer_en = 0, Ser_clk = 0, z = 0. Restart timing is identical to scenario 1.
5. CLK_DIV=3 -> each Ser_clk phase lasts exactly 3 cycles. Ser_data changes only on the cycle Ser_clk falls to 0. No Ser_latch while Ser_clk = 1.
6. LAYER_PWM_EN defined, Duty = 4, LAYER_HOLD = 32 -> Layer_en non-zero on 8 of 32 HOLD cycles. Duty = 0 -> Layer_en stays 0 through HOLD.
